// File: rtl/radar_dds_pkg.sv
// Shared definitions for the radar DDS: sequencer state encoding, default
// datapath widths and the DDS pipeline latency used to align the transmit gate.
package radar_dds_pkg;

   localparam int ACC_W_DEF   = 32;
   localparam int PHASE_W_DEF = 23;
   localparam int LEN_W_DEF   = 16;
   localparam int DDS_LAT_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHIRP = 2'd1,
      ST_GAP   = 2'd2
   } chirp_state_e;

endpackage

// File: rtl/chirp_phase_acc.sv
// Frequency and phase accumulators for one chirp. phase_top is the phase of the
// sample about to be presented; load restarts the chirp at phase 0 / f_start.
module chirp_phase_acc #(
   parameter int ACC_W   = radar_dds_pkg::ACC_W_DEF,
   parameter int PHASE_W = radar_dds_pkg::PHASE_W_DEF
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               load,
   input  logic               en,
   input  logic               down,
   input  logic [ACC_W-1:0]   f_start,
   input  logic [ACC_W-1:0]   k_step,
   output logic [PHASE_W-1:0] phase_top
);

   logic [ACC_W-1:0] phase_q;
   logic [ACC_W-1:0] freq_q;
   logic [ACC_W-1:0] cur_phase;
   logic [ACC_W-1:0] cur_freq;

   // load bypasses the registers so sample 0 can be presented the same cycle
   always_comb begin
      cur_phase = load ? '0 : phase_q;
      cur_freq  = load ? f_start : freq_q;
   end

   assign phase_top = cur_phase[ACC_W-1 -: PHASE_W];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         phase_q <= '0;
         freq_q  <= '0;
      end else if (en) begin
         phase_q <= cur_phase + cur_freq;
         freq_q  <= down ? (cur_freq - k_step) : (cur_freq + k_step);
      end else begin
         phase_q <= '0;
         freq_q  <= f_start;
      end
   end

endmodule

// File: rtl/radar_chirp_seq.sv
// Chirp/burst sequencer for the radar DDS: generates the linear-FM phase word,
// times chirp/gap repetition and produces a transmit gate aligned to DDS output.
module radar_chirp_seq
   import radar_dds_pkg::*;
#(
   parameter int ACC_W   = radar_dds_pkg::ACC_W_DEF,
   parameter int PHASE_W = radar_dds_pkg::PHASE_W_DEF,
   parameter int LEN_W   = radar_dds_pkg::LEN_W_DEF,
   parameter int DDS_LAT = radar_dds_pkg::DDS_LAT_DEF
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [ACC_W-1:0]   f_start,
   input  logic [ACC_W-1:0]   k_step,
   input  logic               down,
   input  logic [LEN_W-1:0]   chirp_len,
   input  logic [LEN_W-1:0]   gap_len,
   input  logic [7:0]         pulse_num,
   output logic [PHASE_W-1:0] rom_addr_reg,
   output logic               busy,
   output logic               pulse_start,
   output logic               tx_en,
   output logic               done,
   output chirp_state_e       state_dbg
);

   // Control semantics: start is a one-cycle request, accepted only in IDLE with
   // a non-zero chirp_len and no stop in the same cycle; there is no ready, an
   // unaccepted start is simply dropped. stop is a level-sampled abort that
   // overrides everything except reset.

   chirp_state_e state, state_nxt;

   logic [ACC_W-1:0]   cfg_f_start;
   logic [ACC_W-1:0]   cfg_k_step;
   logic               cfg_down;
   logic [LEN_W-1:0]   cfg_chirp_len;
   logic [LEN_W-1:0]   cfg_gap_len;
   logic [7:0]         cfg_pulse_num;

   logic [LEN_W-1:0]   chirp_cnt, chirp_cnt_nxt;
   logic [LEN_W-1:0]   gap_cnt, gap_cnt_nxt;
   logic [7:0]         pulse_cnt, pulse_cnt_nxt;
   logic [7:0]         pulse_inc;
   logic               chirp_last;
   logic               gap_last;

   logic               cfg_load;
   logic               acc_load;
   logic               acc_en;
   logic               pulse_start_nxt;
   logic               done_nxt;
   logic [ACC_W-1:0]   acc_f_start;
   logic [ACC_W-1:0]   acc_k_step;
   logic               acc_down;
   logic [PHASE_W-1:0] acc_phase;
   logic [DDS_LAT-1:0] tx_sr;

   assign state_dbg  = state;
   assign pulse_inc  = pulse_cnt + 8'd1;
   assign chirp_last = (chirp_cnt == cfg_chirp_len - LEN_W'(1));
   assign gap_last   = (gap_cnt == cfg_gap_len - LEN_W'(1));
   assign tx_en      = tx_sr[DDS_LAT-1];

   // The first sample of a burst is computed before the config registers load
   always_comb begin
      acc_f_start = (state == ST_IDLE) ? f_start : cfg_f_start;
      acc_k_step  = (state == ST_IDLE) ? k_step  : cfg_k_step;
      acc_down    = (state == ST_IDLE) ? down    : cfg_down;
   end

   chirp_phase_acc #(
      .ACC_W   (ACC_W),
      .PHASE_W (PHASE_W)
   ) u_phase_acc (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .load      (acc_load),
      .en        (acc_en),
      .down      (acc_down),
      .f_start   (acc_f_start),
      .k_step    (acc_k_step),
      .phase_top (acc_phase)
   );

   always_comb begin
      state_nxt       = state;
      chirp_cnt_nxt   = chirp_cnt;
      gap_cnt_nxt     = gap_cnt;
      pulse_cnt_nxt   = pulse_cnt;
      cfg_load        = 1'b0;
      acc_load        = 1'b0;
      acc_en          = 1'b0;
      pulse_start_nxt = 1'b0;
      done_nxt        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!stop && start && (chirp_len != '0)) begin
               state_nxt       = ST_CHIRP;
               cfg_load        = 1'b1;
               acc_load        = 1'b1;
               acc_en          = 1'b1;
               chirp_cnt_nxt   = '0;
               pulse_cnt_nxt   = '0;
               pulse_start_nxt = 1'b1;
            end
         end
         ST_CHIRP: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (chirp_last) begin
               pulse_cnt_nxt = pulse_inc;
               if ((cfg_pulse_num != 8'd0) && (pulse_inc == cfg_pulse_num)) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end else if (cfg_gap_len == '0) begin
                  acc_load        = 1'b1;
                  acc_en          = 1'b1;
                  chirp_cnt_nxt   = '0;
                  pulse_start_nxt = 1'b1;
               end else begin
                  state_nxt   = ST_GAP;
                  gap_cnt_nxt = '0;
               end
            end else begin
               acc_en        = 1'b1;
               chirp_cnt_nxt = chirp_cnt + LEN_W'(1);
            end
         end
         ST_GAP: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (gap_last) begin
               state_nxt       = ST_CHIRP;
               acc_load        = 1'b1;
               acc_en          = 1'b1;
               chirp_cnt_nxt   = '0;
               pulse_start_nxt = 1'b1;
            end else begin
               gap_cnt_nxt = gap_cnt + LEN_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= ST_IDLE;
         chirp_cnt <= '0;
         gap_cnt   <= '0;
         pulse_cnt <= '0;
      end else begin
         state     <= state_nxt;
         chirp_cnt <= chirp_cnt_nxt;
         gap_cnt   <= gap_cnt_nxt;
         pulse_cnt <= pulse_cnt_nxt;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cfg_f_start   <= '0;
         cfg_k_step    <= '0;
         cfg_down      <= 1'b0;
         cfg_chirp_len <= '0;
         cfg_gap_len   <= '0;
         cfg_pulse_num <= '0;
      end else if (cfg_load) begin
         cfg_f_start   <= f_start;
         cfg_k_step    <= k_step;
         cfg_down      <= down;
         cfg_chirp_len <= chirp_len;
         cfg_gap_len   <= gap_len;
         cfg_pulse_num <= pulse_num;
      end
   end

   // Outputs describe the cycle the FSM is entering, so they are all registered
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rom_addr_reg <= '0;
         busy         <= 1'b0;
         pulse_start  <= 1'b0;
         done         <= 1'b0;
         tx_sr        <= '0;
      end else begin
         rom_addr_reg <= (state_nxt == ST_CHIRP) ? acc_phase : '0;
         busy         <= (state_nxt != ST_IDLE);
         pulse_start  <= pulse_start_nxt;
         done         <= done_nxt;
         tx_sr        <= (tx_sr << 1) | DDS_LAT'(state == ST_CHIRP);
      end
   end

endmodule

// File: tb/tb_radar_chirp_seq.sv
// Self-checking bench for radar_chirp_seq: per-cycle expected outputs are built
// from the closed-form chirp phase and compared through an expected queue.
module tb_radar_chirp_seq;
   import radar_dds_pkg::*;

   localparam int ACC_W   = 32;
   localparam int PHASE_W = 23;
   localparam int LEN_W   = 16;
   localparam int DDS_LAT = 5;
   // expected word: [26] in-chirp, [25] busy, [24] pulse_start, [23] done, [22:0] phase
   localparam logic [26:0] IDLE_WORD = '0;

   logic               sys_clk;
   logic               sys_rst_n;
   logic               start;
   logic               stop;
   logic [ACC_W-1:0]   f_start;
   logic [ACC_W-1:0]   k_step;
   logic               down;
   logic [LEN_W-1:0]   chirp_len;
   logic [LEN_W-1:0]   gap_len;
   logic [7:0]         pulse_num;
   logic [PHASE_W-1:0] rom_addr_reg;
   logic               busy;
   logic               pulse_start;
   logic               tx_en;
   logic               done;
   chirp_state_e       state_dbg;

   logic [26:0]        exp_q[$];
   logic [DDS_LAT-1:0] tx_hist;
   bit                 mon_on;
   int                 n_chk;
   int                 n_pass;

   radar_chirp_seq #(
      .ACC_W   (ACC_W),
      .PHASE_W (PHASE_W),
      .LEN_W   (LEN_W),
      .DDS_LAT (DDS_LAT)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .start        (start),
      .stop         (stop),
      .f_start      (f_start),
      .k_step       (k_step),
      .down         (down),
      .chirp_len    (chirp_len),
      .gap_len      (gap_len),
      .pulse_num    (pulse_num),
      .rom_addr_reg (rom_addr_reg),
      .busy         (busy),
      .pulse_start  (pulse_start),
      .tx_en        (tx_en),
      .done         (done),
      .state_dbg    (state_dbg)
   );

   // clock / reset
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", n_chk);
      $fatal(1, "watchdog");
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // scoreboard: every cycle pops one expected word (idle when the queue is empty)
   always @(posedge sys_clk) begin
      logic [26:0] w;
      #1;
      if (mon_on) begin
         w = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_WORD;
         chk_eq("outputs", {6'd0, busy, pulse_start, done, rom_addr_reg}, {6'd0, w[25:0]});
         chk_eq("tx_en", {31'd0, tx_en}, {31'd0, tx_hist[DDS_LAT-1]});
         tx_hist = {tx_hist[DDS_LAT-2:0], w[26]};
      end
   end

   // expected sequence from the closed form n*f +/- k*n(n-1)/2
   task automatic push_burst(input logic [31:0] f, input logic [31:0] k, input bit dn,
                             input int cl, input int gl, input int np_cfg, input int np_gen);
      logic [63:0] nn, t1, t2, ph;
      for (int p = 0; p < np_gen; p++) begin
         for (int n = 0; n < cl; n++) begin
            nn = 64'(n);
            t1 = nn * {32'd0, f};
            t2 = {32'd0, k} * ((nn * (nn - 64'd1)) >> 1);
            ph = dn ? (t1 - t2) : (t1 + t2);
            exp_q.push_back({1'b1, 1'b1, (n == 0), 1'b0, ph[31:9]});
         end
         if (np_cfg != 0 && p == np_gen - 1)
            exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 23'd0});
         else
            for (int g = 0; g < gl; g++) exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 23'd0});
      end
   endtask

   // drives start for one cycle, then scrambles the config inputs mid-burst
   task automatic start_burst(input logic [31:0] f, input logic [31:0] k, input bit dn,
                              input int cl, input int gl, input int np_cfg, input int np_gen);
      @(negedge sys_clk);
      f_start   = f;
      k_step    = k;
      down      = dn;
      chirp_len = LEN_W'(cl);
      gap_len   = LEN_W'(gl);
      pulse_num = 8'(np_cfg);
      start     = 1'b1;
      if (cl != 0) push_burst(f, k, dn, cl, gl, np_cfg, np_gen);
      @(negedge sys_clk);
      start     = 1'b0;
      f_start   = $urandom;
      k_step    = $urandom;
      down      = 1'($urandom_range(0, 1));
      chirp_len = LEN_W'($urandom_range(0, 9));
      gap_len   = LEN_W'($urandom_range(0, 4));
      pulse_num = 8'($urandom_range(0, 5));
   endtask

   task automatic wait_drain();
      int cnt = 0;
      while (exp_q.size() != 0 && cnt < 2000) begin
         @(negedge sys_clk);
         cnt++;
      end
      chk_eq("drain", exp_q.size(), 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; mon_on = 1'b0; tx_hist = '0;
      sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0;
      f_start = '0; k_step = '0; down = 1'b0;
      chirp_len = '0; gap_len = '0; pulse_num = '0;
      idle(2);
      chk_eq("reset_outputs", {6'd0, busy, pulse_start, done, rom_addr_reg}, 32'd0);
      chk_eq("reset_tx_en", {31'd0, tx_en}, 32'd0);
      sys_rst_n = 1'b1;
      mon_on    = 1'b1;
      idle(2);

      // constant tone, two pulses with a two-cycle gap
      start_burst(32'h0100_0000, 32'h0, 1'b0, 4, 2, 2, 2);
      wait_drain(); idle(DDS_LAT + 2);
      // up-chirp and down-chirp with wrap
      start_burst(32'h0, 32'h200, 1'b0, 4, 0, 1, 1);
      wait_drain(); idle(3);
      start_burst(32'h0, 32'h200, 1'b1, 4, 0, 1, 1);
      wait_drain(); idle(DDS_LAT + 2);
      // back-to-back pulses, with a start request while busy
      start_burst(32'h0123_4567, 32'h0000_0010, 1'b0, 3, 0, 3, 3);
      idle(3);
      chirp_len = 16'd7; start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      wait_drain(); idle(DDS_LAT + 2);
      // start with chirp_len 0 is ignored
      start_burst(32'h0100_0000, 32'h0, 1'b0, 0, 1, 1, 1);
      idle(4);
      // simultaneous start and stop in IDLE
      chirp_len = 16'd4; pulse_num = 8'd1; start = 1'b1; stop = 1'b1;
      @(negedge sys_clk);
      start = 1'b0; stop = 1'b0;
      idle(4);
      // continuous mode, stop mid-chirp of the third pulse
      start_burst(32'h0040_0000, 32'h0000_1000, 1'b0, 5, 3, 0, 4);
      idle(19);
      stop = 1'b1;
      exp_q.delete();
      @(negedge sys_clk);
      stop = 1'b0;
      idle(DDS_LAT + 3);
      // random bursts
      for (int r = 0; r < 5; r++) begin
         int cl, gl, np;
         cl = $urandom_range(1, 6);
         gl = $urandom_range(0, 3);
         np = $urandom_range(1, 3);
         start_burst($urandom, $urandom, 1'($urandom_range(0, 1)), cl, gl, np, np);
         wait_drain(); idle($urandom_range(1, 6));
      end
      idle(DDS_LAT + 2);
      // async reset in the middle of the gap, then a fresh burst
      start_burst(32'h0100_0000, 32'h0, 1'b0, 4, 2, 2, 2);
      idle(4);
      sys_rst_n = 1'b0;
      exp_q.delete();
      tx_hist = '0;
      #1;
      chk_eq("async_reset_outputs", {6'd0, busy, pulse_start, done, rom_addr_reg}, 32'd0);
      chk_eq("async_reset_tx_en", {31'd0, tx_en}, 32'd0);
      idle(2);
      sys_rst_n = 1'b1;
      idle(1);
      start_burst(32'h0100_0000, 32'h0, 1'b0, 4, 2, 2, 2);
      wait_drain(); idle(DDS_LAT + 2);

      mon_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/radar_chirp_seq.md
# radar_chirp_seq

Pulse/burst sequencer for the radar DDS. It generates the linear-FM (chirp) phase word that drives the DDS sine/cosine datapath on `rom_addr_reg[22:0]`, and it times pulse repetition: chirp, gap, chirp, and so on, for N pulses or continuously. It also provides a transmit gate delayed to line up with the DDS output samples. It sits between the register/control logic and the DDS core.

## Interface
Parameters:
- `ACC_W`, default 32: phase and frequency accumulator width.
- `PHASE_W`, default 23: output phase width, taken from the top bits of the accumulator (`ACC_W >= PHASE_W`).
- `LEN_W`, default 16: width of the chirp and gap length counters.
- `DDS_LAT`, default 5: DDS pipeline latency in clocks; `tx_en` is delayed by this amount.

Ports:
- `sys_clk`, in, 1: clock. One clock domain only.
- `sys_rst_n`, in, 1: reset. Asynchronous, active-low.
- `start`, in, 1: one-cycle burst start request; honoured only in IDLE.
- `stop`, in, 1: abort; has priority over everything except reset.
- `f_start`, in, ACC_W: start frequency word.
- `k_step`, in, ACC_W: chirp rate, i.e. the frequency-word increment per clock.
- `down`, in, 1: 1 = frequency decrements by `k_step` (down-chirp).
- `chirp_len`, in, LEN_W: chirp length in clocks; 0 is illegal.
- `gap_len`, in, LEN_W: idle clocks between pulses; 0 means back-to-back pulses.
- `pulse_num`, in, 8: pulses per burst; 0 means continuous until `stop`.
- `rom_addr_reg`, out, PHASE_W: phase word to the DDS.
- `busy`, out, 1: high whenever not in IDLE.
- `pulse_start`, out, 1: one-cycle pulse on the first phase sample of each chirp.
- `tx_en`, out, 1: chirp-active gate, delayed `DDS_LAT` clocks.
- `done`, out, 1: one-cycle pulse when a finite burst completes.

## Operation
- States: IDLE, CHIRP, GAP.
- IDLE:
  - Phase accumulator = 0, `rom_addr_reg` = 0.
  - On `start` with `chirp_len != 0`: latch all config inputs, set freq = `f_start`, phase = 0, chirp counter = 0, pulse counter = 0, then go to CHIRP.
  - `start` with `chirp_len == 0` is ignored: stay in IDLE, no `done`.
- Config inputs are sampled only at start. Changes during a burst take effect at the next burst.
- CHIRP, each clock:
  - Present `rom_addr_reg = phase[ACC_W-1 -: PHASE_W]`.
  - Update `phase += freq` and `freq ± k_step` (chosen by `down`).
  - All arithmetic is modulo 2^ACC_W; wrap is silent.
  - Chirp sample n (n = 0..chirp_len-1) has phase = n·f_start ± k_step·n(n−1)/2 (mod 2^ACC_W).
- End of chirp (sample `chirp_len-1`):
  - Increment the pulse counter.
  - If `pulse_num != 0` and the count reaches `pulse_num`: go to IDLE and pulse `done`. The last pulse has no trailing gap.
  - Otherwise, if `gap_len == 0`: restart CHIRP directly (reload phase = 0, freq = `f_start`).
  - Otherwise: go to GAP.
- GAP:
  - `rom_addr_reg` = 0, phase held at 0.
  - Count `gap_len` clocks, then enter CHIRP with freq reloaded to `f_start`.
- `stop` in any state: next cycle is IDLE, phase = 0, no `done`. The `tx_en` pipeline continues to drain naturally.
- Simultaneous `start` and `stop` in IDLE: `stop` wins and the sequencer stays in IDLE.
- `start` while busy is ignored.

## Timing
- Reset values: `rom_addr_reg` = 0, `busy` = 0, `pulse_start` = 0, `tx_en` = 0, `done` = 0, state = IDLE, the `tx_en` delay line all zeros.
- All outputs are registered.
- `start` accepted at edge T: CHIRP sample 0 appears on `rom_addr_reg` in the cycle after T, with `pulse_start` = 1 and `busy` = 1 in that same cycle.
- Sample-to-sample spacing is 1 clock. No bubbles between back-to-back pulses (`gap_len = 0`).
- GAP of length G inserts exactly G cycles of phase 0 between the last sample of one chirp and sample 0 of the next.
- `done` is high in the first IDLE cycle after the final chirp sample; `busy` is low in that same cycle.
- `tx_en` equals the internal "in CHIRP" flag delayed by `DDS_LAT` registers, so it is aligned with the DDS output samples.
- Asynchronous reset mid-burst forces the reset values immediately, including clearing the delay line.

## Structure
- Shared package `radar_dds_pkg`: state encoding (IDLE/CHIRP/GAP), default widths (ACC_W, PHASE_W, LEN_W), and the DDS_LAT constant shared with the DDS core.
- One sub-module, `chirp_phase_acc`: the frequency and phase accumulators with load/enable/direction controls. The FSM and counters stay in the top level.
- `tx_en` delay uses a simple shift register in the top level.

## Test plan
- Constant tone: `f_start` = 0x0100_0000, `k_step` = 0, `chirp_len` = 4, `gap_len` = 2, `pulse_num` = 2.
  - Required: `rom_addr_reg` sequence 0, 0x8000, 0x10000, 0x18000, 0, 0, 0, 0x8000, 0x10000, 0x18000.
  - `pulse_start` on both sample 0s; `done` 1 cycle after the last sample.
- Up-chirp: `f_start` = 0, `k_step` = 0x200, `chirp_len` = 4, `pulse_num` = 1.
  - Required phase samples: 0, 0, 1, 3.
  - With `down` = 1: 0, 0, 0x7FFFFF, 0x7FFFFD (wrap).
- Back-to-back: `gap_len` = 0, `chirp_len` = 3, `pulse_num` = 3.
  - Required: 9 consecutive busy sample cycles, phase reloads to 0 every 3 samples, then `done`.
- Continuous mode with abort: `pulse_num` = 0.
  - Required: runs indefinitely.
  - `stop` mid-chirp: IDLE next cycle, `rom_addr_reg` = 0, no `done`.
  - `tx_en` falls exactly `DDS_LAT` cycles after CHIRP exits.
- Illegal and ignored requests:
  - `start` with `chirp_len` = 0: no response.
  - `start` while busy: ignored.
  - Simultaneous `start` and `stop` in IDLE: stays IDLE.
- Async reset asserted mid-GAP: all outputs return to 0 immediately.
  - A new `start` after reset release behaves as in the first scenario.
